// File: rtl/dma_copia_pkg.sv
// Shared state encoding and default widths for the byte-serial copy engine.
package dma_copia_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LER     = 3'd1;
  localparam logic [2:0] ST_CAPTURA = 3'd2;
  localparam logic [2:0] ST_ESCRITA = 3'd3;
  localparam logic [2:0] ST_FIM     = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    LER     = ST_LER,
    CAPTURA = ST_CAPTURA,
    ESCRITA = ST_ESCRITA,
    FIM     = ST_FIM
  } state_t;

endpackage

// File: rtl/dma_copia_if.sv
// Control and data-memory bus of dma_copia; master = copy engine, slave = host/memory side.
interface dma_copia_if #(
  parameter int ADDR_W = dma_copia_pkg::ADDR_W_DEF,
  parameter int DATA_W = dma_copia_pkg::DATA_W_DEF
);

  logic              Inicio;
  logic [ADDR_W-1:0] Origem;
  logic [ADDR_W-1:0] Destino;
  logic [ADDR_W-1:0] Tamanho;
  logic              Ocupado;
  logic              Concluido;
  logic [ADDR_W-1:0] Endereco;
  logic [DATA_W-1:0] DadoEscr;
  logic [DATA_W-1:0] DadoLido;
  logic              MenWrite;
  logic              MenRead;
  logic [DATA_W-1:0] Soma;

  modport master (
    input  Inicio, Origem, Destino, Tamanho, DadoLido,
    output Ocupado, Concluido, Endereco, DadoEscr, MenWrite, MenRead, Soma
  );

  modport slave (
    output Inicio, Origem, Destino, Tamanho, DadoLido,
    input  Ocupado, Concluido, Endereco, DadoEscr, MenWrite, MenRead, Soma
  );

endinterface

// File: rtl/dma_copia.sv
// Byte-serial memory copy: 3 cycles per byte (LER/CAPTURA/ESCRITA) plus one FIM cycle; no backpressure.
// Optional XOR checksum on Soma when DMA_COPIA_CHECKSUM_EN is defined, otherwise Soma is tied to 0.
module dma_copia
  import dma_copia_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic         Clock,
  input logic         Reset,
  dma_copia_if.master bus
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_orig;
  logic [ADDR_W-1:0] r_dest;
  logic [ADDR_W-1:0] r_tam;
  logic [ADDR_W-1:0] r_i;
  logic [DATA_W-1:0] r_buf;

  logic              w_last;
  logic              w_accept;
  logic              w_ocupado;
  logic              w_concluido;
  logic              w_rd;
  logic              w_wr;
  logic [ADDR_W-1:0] w_end;

  assign w_last   = (r_i == r_tam - ADDR_W'(1));
  assign w_accept = (r_state == IDLE) && bus.Inicio;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Outputs depend on r_state and datapath registers only; Inicio/Tamanho steer w_next alone.
  always_comb begin
    w_next      = r_state;
    w_ocupado   = 1'b1;
    w_concluido = 1'b0;
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    w_end       = '0;
    unique case (r_state)
      IDLE: begin
        w_ocupado = 1'b0;
        if (bus.Inicio) w_next = (bus.Tamanho == '0) ? FIM : LER;
      end
      LER: begin
        w_rd   = 1'b1;
        w_end  = r_orig + r_i;
        w_next = CAPTURA;
      end
      CAPTURA: w_next = ESCRITA;
      ESCRITA: begin
        w_wr   = 1'b1;
        w_end  = r_dest + r_i;
        w_next = w_last ? FIM : LER;
      end
      FIM: begin
        w_concluido = 1'b1;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_orig <= '0;
      r_dest <= '0;
      r_tam  <= '0;
      r_i    <= '0;
      r_buf  <= '0;
    end else begin
      if (w_accept) begin
        r_orig <= bus.Origem;
        r_dest <= bus.Destino;
        r_tam  <= bus.Tamanho;
        r_i    <= '0;
      end
      // Memory returns read data one cycle after MenRead, so the byte is taken here.
      if (r_state == CAPTURA) r_buf <= bus.DadoLido;
      if ((r_state == ESCRITA) && !w_last) r_i <= r_i + ADDR_W'(1);
    end
  end

`ifdef DMA_COPIA_CHECKSUM_EN
  logic [DATA_W-1:0] r_soma;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                   r_soma <= '0;
    else if (w_accept)           r_soma <= '0;
    else if (r_state == CAPTURA) r_soma <= r_soma ^ bus.DadoLido;
  end

  assign bus.Soma = r_soma;
`else
  assign bus.Soma = '0;
`endif

  assign bus.Ocupado   = w_ocupado;
  assign bus.Concluido = w_concluido;
  assign bus.MenRead   = w_rd;
  assign bus.MenWrite  = w_wr;
  assign bus.Endereco  = w_end;
  assign bus.DadoEscr  = r_buf;

endmodule

// File: tb/tb_dma_copia.sv
// Directed bench for dma_copia paired with a registered-read byte memory.
module tb_dma_copia;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pre = 1'b0;

  always #5 clk = ~clk;

  dma_copia_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  dma_copia #(.ADDR_W(8), .DATA_W(8)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
    end else if (bus.MenWrite) begin
      mem[bus.Endereco] <= bus.DadoEscr;
    end
    if (bus.MenRead) bus.DadoLido <= mem[bus.Endereco];
  end

  // Whole-run monitor: strobe overlap, Concluido width, event counts.
  logic overlap_seen = 1'b0;
  logic wide_seen    = 1'b0;
  logic prev_conc    = 1'b0;
  int   conc_cnt     = 0;
  int   rd_cnt       = 0;
  int   wr_cnt       = 0;

  always @(negedge clk) begin
    if (bus.MenRead && bus.MenWrite) overlap_seen <= 1'b1;
    if (bus.Concluido && prev_conc) wide_seen <= 1'b1;
    if (bus.Concluido && !prev_conc) conc_cnt <= conc_cnt + 1;
    if (bus.MenRead) rd_cnt <= rd_cnt + 1;
    if (bus.MenWrite) wr_cnt <= wr_cnt + 1;
    prev_conc <= bus.Concluido;
  end

  int vec = 0;
  int err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload();
    @(negedge clk);
    pre = 1'b1;
    @(negedge clk);
    pre = 1'b0;
  endtask

  // Returns the cycle after the accepting edge in which Concluido is seen, -1 on timeout.
  task automatic run(input logic [7:0] o, input logic [7:0] d, input logic [7:0] t,
                     output int cyc);
    @(negedge clk);
    bus.Origem  = o;
    bus.Destino = d;
    bus.Tamanho = t;
    bus.Inicio  = 1'b1;
    @(posedge clk);
    #1 bus.Inicio = 1'b0;
    cyc = -1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (bus.Concluido) begin
        cyc = k;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int rd0, wr0, c0, wseen;
    logic [7:0] exp_soma;

    bus.Inicio  = 1'b0;
    bus.Origem  = '0;
    bus.Destino = '0;
    bus.Tamanho = '0;

    // Reset state, checked with the clock running and reset still high.
    repeat (2) @(negedge clk);
    check("rst_ocupado",   bus.Ocupado,   1'b0);
    check("rst_concluido", bus.Concluido, 1'b0);
    check("rst_menread",   bus.MenRead,   1'b0);
    check("rst_menwrite",  bus.MenWrite,  1'b0);
    check("rst_endereco",  bus.Endereco,  8'h00);
    check("rst_dadoescr",  bus.DadoEscr,  8'h00);
    check("rst_soma",      bus.Soma,      8'h00);
    rst = 1'b0;
    preload();

    // Basic 4-byte copy 0x10 -> 0x80.
    run(8'h10, 8'h80, 8'd4, cyc);
    check("s1_cycle", cyc, 13);
    check("s1_mem80", mem[8'h80], 8'h10);
    check("s1_mem81", mem[8'h81], 8'h11);
    check("s1_mem82", mem[8'h82], 8'h12);
    check("s1_mem83", mem[8'h83], 8'h13);
    check("s1_soma", bus.Soma, 8'h00);
    check("s1_idle", bus.Ocupado, 1'b0);

    // Zero-length transfer: FIM straight away, no strobes.
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    run(8'h33, 8'h44, 8'd0, cyc);
    check("s2_cycle", cyc, 1);
    check("s2_reads", rd_cnt - rd0, 0);
    check("s2_writes", wr_cnt - wr0, 0);

    // Source wraps 0xFE, 0xFF, 0x00.
    run(8'hFE, 8'h20, 8'd3, cyc);
`ifdef DMA_COPIA_CHECKSUM_EN
    exp_soma = 8'h01;
`else
    exp_soma = 8'h00;
`endif
    check("s3_cycle", cyc, 10);
    check("s3_mem20", mem[8'h20], 8'hFE);
    check("s3_mem21", mem[8'h21], 8'hFF);
    check("s3_mem22", mem[8'h22], 8'h00);
    check("s3_soma", bus.Soma, exp_soma);

    // Reset during the second ESCRITA of a 5-byte copy 0x40 -> 0x90.
    preload();
    @(negedge clk);
    bus.Origem  = 8'h40;
    bus.Destino = 8'h90;
    bus.Tamanho = 8'd5;
    bus.Inicio  = 1'b1;
    @(posedge clk);
    #1 bus.Inicio = 1'b0;
    wseen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.MenWrite) wseen++;
      if (wseen == 2) break;
    end
    check("s4_reached_2nd_write", wseen, 2);
    rst = 1'b1;
    #1;
    check("s4_menwrite_drop", bus.MenWrite, 1'b0);
    check("s4_ocupado_drop", bus.Ocupado, 1'b0);
    check("s4_endereco_clr", bus.Endereco, 8'h00);
    c0 = conc_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("s4_no_concluido", conc_cnt - c0, 0);
    check("s4_mem90", mem[8'h90], 8'h40);
    check("s4_mem91", mem[8'h91], 8'h91);

    // Inicio while busy and in FIM must both be ignored.
    preload();
    @(negedge clk);
    bus.Origem  = 8'h00;
    bus.Destino = 8'hA0;
    bus.Tamanho = 8'd4;
    bus.Inicio  = 1'b1;
    @(posedge clk);
    #1 bus.Inicio = 1'b0;
    cyc = -1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (k == 3) begin
        check("s5_busy", bus.Ocupado, 1'b1);
        bus.Origem  = 8'h50;
        bus.Tamanho = 8'd1;
        bus.Inicio  = 1'b1;
        @(posedge clk);
        #1 bus.Inicio = 1'b0;
        continue;
      end
      if (bus.Concluido) begin
        cyc = k;
        bus.Origem  = 8'h60;
        bus.Destino = 8'hC0;
        bus.Tamanho = 8'd2;
        bus.Inicio  = 1'b1;
        @(posedge clk);
        #1 bus.Inicio = 1'b0;
        break;
      end
    end
    check("s5_cycle", cyc, 13);
    @(negedge clk);
    check("s5_idle_after_fim", bus.Ocupado, 1'b0);
    @(negedge clk);
    check("s5_still_idle", bus.Ocupado, 1'b0);
    check("s5_memA0", mem[8'hA0], 8'h00);
    check("s5_memA3", mem[8'hA3], 8'h03);
    check("s5_memC0_untouched", mem[8'hC0], 8'hC0);
    run(8'h60, 8'hB0, 8'd2, cyc);
    check("s5_later_cycle", cyc, 7);
    check("s5_memB0", mem[8'hB0], 8'h60);
    check("s5_memB1", mem[8'hB1], 8'h61);

    check("run_no_strobe_overlap", overlap_seen, 1'b0);
    check("run_concluido_one_cycle", wide_seen, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
